// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, funct7 values, ALU op encoding and immediate formats.
// Optional M-extension ALU codes are present when DECODE_RV32M_EN is defined.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_SLL    = 4'h2;
  localparam logic [3:0] ALU_SLT    = 4'h3;
  localparam logic [3:0] ALU_SLTU   = 4'h4;
  localparam logic [3:0] ALU_XOR    = 4'h5;
  localparam logic [3:0] ALU_SRL    = 4'h6;
  localparam logic [3:0] ALU_SRA    = 4'h7;
  localparam logic [3:0] ALU_OR     = 4'h8;
  localparam logic [3:0] ALU_AND    = 4'h9;
`ifdef DECODE_RV32M_EN
  // Only 16 codes exist: REM/REMU alias DIV/DIVU and execute splits them on funct3[1].
  localparam logic [3:0] ALU_MUL    = 4'hA;
  localparam logic [3:0] ALU_MULH   = 4'hB;
  localparam logic [3:0] ALU_MULHSU = 4'hC;
  localparam logic [3:0] ALU_MULHU  = 4'hD;
  localparam logic [3:0] ALU_DIV    = 4'hE;
  localparam logic [3:0] ALU_DIVU   = 4'hF;
  localparam logic [3:0] ALU_REM    = 4'hE;
  localparam logic [3:0] ALU_REMU   = 4'hF;
`endif

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  function automatic logic [3:0] base_alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

`ifdef DECODE_RV32M_EN
  function automatic logic [3:0] muldiv_alu_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction
`endif

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects and sign-extends the RV32I immediate by format.
module decode_stage_imm_gen
  import decode_pkg::*;
(
  input  logic [31:7] ir,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'h0;
    case (imm_type)
      IMM_I: imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U: imm = {ir[31:12], 12'h000};
      IMM_J: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with registered ID/EX outputs, load-use stall, flush and bubble counter.
// Define DECODE_RV32M_EN to accept the M-extension (funct7=0000001) OP encodings.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_8000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic [31:0]      pc1,
  input  logic             valid_in,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  output logic             stall_out,
  output logic             valid_out,
  output logic [31:0]      pc_out,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [31:0]      imm,
  output logic [2:0]       funct3,
  output logic [3:0]       alu_op,
  output logic             is_load,
  output logic             is_store,
  output logic             is_branch,
  output logic             is_jal,
  output logic             is_jalr,
  output logic             is_lui,
  output logic             is_auipc,
  output logic             reg_we,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [6:0]  w_opcode;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm;
  imm_type_e   w_imm_type;
  logic [3:0]  w_alu_op;
  logic        w_illegal, w_writes, w_uses_rs1, w_uses_rs2;
  logic        w_load, w_store, w_branch, w_jal, w_jalr, w_lui, w_auipc;
  logic        w_reg_we, w_hazard;

  logic             r_valid;
  logic [31:0]      r_pc;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic [31:0]      r_imm;
  logic [2:0]       r_funct3;
  logic [3:0]       r_alu_op;
  logic             r_load, r_store, r_branch, r_jal, r_jalr, r_lui, r_auipc;
  logic             r_reg_we, r_illegal;
  logic [CNT_W-1:0] r_bubble_cnt;

  assign w_opcode = ir[6:0];
  assign w_rd     = ir[11:7];
  assign w_f3     = ir[14:12];
  assign w_rs1    = ir[19:15];
  assign w_rs2    = ir[24:20];
  assign w_f7     = ir[31:25];

  always_comb begin
    w_illegal  = 1'b0;
    w_writes   = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_load     = 1'b0;
    w_store    = 1'b0;
    w_branch   = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_lui      = 1'b0;
    w_auipc    = 1'b0;
    w_alu_op   = ALU_ADD;
    w_imm_type = IMM_I;
    if (ir[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OPC_LUI:   begin w_lui = 1'b1; w_writes = 1'b1; w_imm_type = IMM_U; end
        OPC_AUIPC: begin w_auipc = 1'b1; w_writes = 1'b1; w_imm_type = IMM_U; end
        OPC_JAL:   begin w_jal = 1'b1; w_writes = 1'b1; w_imm_type = IMM_J; end
        OPC_JALR:  begin w_jalr = 1'b1; w_writes = 1'b1; w_uses_rs1 = 1'b1; end
        OPC_BRANCH: begin
          w_branch   = 1'b1;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
          w_imm_type = IMM_B;
          w_alu_op   = ALU_SUB;
        end
        OPC_LOAD:  begin w_load = 1'b1; w_writes = 1'b1; w_uses_rs1 = 1'b1; end
        OPC_STORE: begin
          w_store    = 1'b1;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
          w_imm_type = IMM_S;
        end
        OPC_OPIMM: begin
          w_writes   = 1'b1;
          w_uses_rs1 = 1'b1;
          w_alu_op   = base_alu_op(w_f3, 1'b0);
          // Shift-immediates reuse funct7 to pick SRL/SRA; anything else there is illegal.
          if (w_f3 == 3'b001 && w_f7 != F7_BASE) w_illegal = 1'b1;
          if (w_f3 == 3'b101) begin
            if (w_f7 == F7_ALT)        w_alu_op  = ALU_SRA;
            else if (w_f7 != F7_BASE)  w_illegal = 1'b1;
          end
        end
        OPC_OP: begin
          w_writes   = 1'b1;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
          if (w_f7 == F7_BASE)
            w_alu_op = base_alu_op(w_f3, 1'b0);
          else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))
            w_alu_op = base_alu_op(w_f3, 1'b1);
`ifdef DECODE_RV32M_EN
          else if (w_f7 == F7_MULDIV)
            w_alu_op = muldiv_alu_op(w_f3);
`endif
          else
            w_illegal = 1'b1;
        end
        default: w_illegal = 1'b1;
      endcase
    end
    if (w_illegal) begin
      w_writes = 1'b0;
      w_load   = 1'b0;
      w_store  = 1'b0;
      w_branch = 1'b0;
      w_jal    = 1'b0;
      w_jalr   = 1'b0;
      w_lui    = 1'b0;
      w_auipc  = 1'b0;
    end
  end

  decode_stage_imm_gen u_imm_gen (
    .ir       (ir[31:7]),
    .imm_type (w_imm_type),
    .imm      (w_imm)
  );

  assign w_reg_we  = w_writes & (w_rd != 5'd0);
  assign w_hazard  = valid_in & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                     ((w_uses_rs1 & (w_rs1 == ex_rd)) | (w_uses_rs2 & (w_rs2 == ex_rd)));
  assign stall_out = stall_in | (w_hazard & ~flush);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_pc         <= RESET_PC;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_funct3     <= '0;
      r_alu_op     <= '0;
      r_load       <= 1'b0;
      r_store      <= 1'b0;
      r_branch     <= 1'b0;
      r_jal        <= 1'b0;
      r_jalr       <= 1'b0;
      r_lui        <= 1'b0;
      r_auipc      <= 1'b0;
      r_reg_we     <= 1'b0;
      r_illegal    <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (stall_in) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
      if (r_bubble_cnt != {CNT_W{1'b1}})
        r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_valid   <= valid_in;
      r_pc      <= pc1;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_imm     <= w_imm;
      r_funct3  <= w_f3;
      r_alu_op  <= w_alu_op;
      r_load    <= w_load;
      r_store   <= w_store;
      r_branch  <= w_branch;
      r_jal     <= w_jal;
      r_jalr    <= w_jalr;
      r_lui     <= w_lui;
      r_auipc   <= w_auipc;
      r_reg_we  <= w_reg_we;
      r_illegal <= w_illegal;
    end
  end

  assign valid_out  = r_valid;
  assign pc_out     = r_pc;
  assign rs1        = r_rs1;
  assign rs2        = r_rs2;
  assign rd         = r_rd;
  assign imm        = r_imm;
  assign funct3     = r_funct3;
  assign alu_op     = r_alu_op;
  assign is_load    = r_load;
  assign is_store   = r_store;
  assign is_branch  = r_branch;
  assign is_jal     = r_jal;
  assign is_jalr    = r_jalr;
  assign is_lui     = r_lui;
  assign is_auipc   = r_auipc;
  assign reg_we     = r_reg_we;
  assign illegal    = r_illegal;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; a narrow bubble counter makes saturation reachable.
// Build with DECODE_RV32M_EN defined to check the M-extension expectations instead.
module tb_decode_stage;

  localparam int TB_CNT_W = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [31:0]         ir, pc1;
  logic                valid_in, stall_in, flush, ex_valid, ex_is_load;
  logic [4:0]          ex_rd;
  logic                stall_out, valid_out;
  logic [31:0]         pc_out, imm;
  logic [4:0]          rs1, rs2, rd;
  logic [2:0]          funct3;
  logic [3:0]          alu_op;
  logic                is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic                reg_we, illegal;
  logic [TB_CNT_W-1:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(.RESET_PC(32'h0000_8000), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .ir(ir), .pc1(pc1), .valid_in(valid_in),
    .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .stall_out(stall_out), .valid_out(valid_out), .pc_out(pc_out),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .funct3(funct3), .alu_op(alu_op),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .is_lui(is_lui), .is_auipc(is_auipc), .reg_we(reg_we),
    .illegal(illegal), .bubble_cnt(bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ir = 32'h00500093; pc1 = 32'h40; valid_in = 1'b1;
    tick();
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid_out); end
    n_tests++; if (pc_out !== 32'h8000) begin n_fail++; $display("FAIL reset_pc got %h want 00008000", pc_out); end
    n_tests++; if (bubble_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_bubble got %0d want 0", bubble_cnt); end
    n_tests++; if ({rd, imm, reg_we} !== 38'd0) begin n_fail++; $display("FAIL reset_fields rd=%0d imm=%h we=%0b want 0", rd, imm, reg_we); end
    reset = 1'b1;
  endtask

  task automatic test_decode();
    ir = 32'h00500093; pc1 = 32'h100; valid_in = 1'b1;  // addi x1,x0,5
    tick();
    n_tests++; if ({valid_out, rd, rs1, imm} !== {1'b1, 5'd1, 5'd0, 32'd5}) begin n_fail++; $display("FAIL addi_fields v=%0b rd=%0d rs1=%0d imm=%h", valid_out, rd, rs1, imm); end
    n_tests++; if ({alu_op, reg_we, illegal, pc_out} !== {4'h0, 1'b1, 1'b0, 32'h100}) begin n_fail++; $display("FAIL addi_ctl alu=%h we=%0b ill=%0b pc=%h", alu_op, reg_we, illegal, pc_out); end
    ir = 32'hFE000CE3; pc1 = 32'h104;  // beq x0,x0,-8
    tick();
    n_tests++; if (imm !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL beq_imm got %h want fffffff8", imm); end
    n_tests++; if ({is_branch, reg_we, alu_op, valid_out} !== {1'b1, 1'b0, 4'h1, 1'b1}) begin n_fail++; $display("FAIL beq_ctl br=%0b we=%0b alu=%h v=%0b", is_branch, reg_we, alu_op, valid_out); end
    ir = 32'h123450B7; pc1 = 32'h108;  // lui x1,0x12345
    tick();
    n_tests++; if ({imm, is_lui, rd, reg_we} !== {32'h1234_5000, 1'b1, 5'd1, 1'b1}) begin n_fail++; $display("FAIL lui imm=%h lui=%0b rd=%0d we=%0b", imm, is_lui, rd, reg_we); end
    ir = 32'h0020A423; pc1 = 32'h10C;  // sw x2,8(x1)
    tick();
    n_tests++; if ({imm, is_store, rs1, rs2, reg_we, funct3} !== {32'd8, 1'b1, 5'd1, 5'd2, 1'b0, 3'b010}) begin n_fail++; $display("FAIL sw imm=%h st=%0b rs1=%0d rs2=%0d we=%0b f3=%0d", imm, is_store, rs1, rs2, reg_we, funct3); end
    ir = 32'h00500093; pc1 = 32'h110; valid_in = 1'b0;
    tick();
    n_tests++; if ({valid_out, pc_out, rd} !== {1'b0, 32'h110, 5'd1}) begin n_fail++; $display("FAIL invalid_in v=%0b pc=%h rd=%0d want 0/110/1", valid_out, pc_out, rd); end
  endtask

  task automatic test_hazard();
    ir = 32'h002081B3; pc1 = 32'h114; valid_in = 1'b1;  // add x3,x1,x2
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
    #1;
    n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL hz_rs1_stall got %0b want 1", stall_out); end
    tick();
    n_tests++; if ({valid_out, bubble_cnt, pc_out} !== {1'b0, 3'd1, 32'h110}) begin n_fail++; $display("FAIL hz_bubble v=%0b cnt=%0d pc=%h", valid_out, bubble_cnt, pc_out); end
    ex_valid = 1'b0;
    #1;
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL hz_release_stall got %0b want 0", stall_out); end
    tick();
    n_tests++; if ({valid_out, rd, pc_out, bubble_cnt} !== {1'b1, 5'd3, 32'h114, 3'd1}) begin n_fail++; $display("FAIL hz_issue v=%0b rd=%0d pc=%h cnt=%0d", valid_out, rd, pc_out, bubble_cnt); end
    ex_valid = 1'b1; ex_rd = 5'd0;
    #1;
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL hz_x0_stall got %0b want 0", stall_out); end
    tick();
    n_tests++; if ({valid_out, bubble_cnt} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL hz_x0 v=%0b cnt=%0d", valid_out, bubble_cnt); end
    ex_rd = 5'd2;
    #1;
    n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL hz_rs2_stall got %0b want 1", stall_out); end
    tick();
    n_tests++; if ({valid_out, bubble_cnt} !== {1'b0, 3'd2}) begin n_fail++; $display("FAIL hz_rs2 v=%0b cnt=%0d", valid_out, bubble_cnt); end
    ex_is_load = 1'b0;
    #1;
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL hz_noload_stall got %0b want 0", stall_out); end
    tick();
    n_tests++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL hz_noload v=%0b want 1", valid_out); end
  endtask

  task automatic test_flush();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1; flush = 1'b1;
    #1;
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_masks_hz got %0b want 0", stall_out); end
    stall_in = 1'b1;
    #1;
    n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL flush_stall_in got %0b want 1", stall_out); end
    tick();
    n_tests++; if ({valid_out, bubble_cnt} !== {1'b0, 3'd2}) begin n_fail++; $display("FAIL flush v=%0b cnt=%0d want 0/2", valid_out, bubble_cnt); end
    flush = 1'b0; stall_in = 1'b0; ex_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] stall_irs [3];
    stall_irs[0] = 32'h00500093; stall_irs[1] = 32'hFE000CE3; stall_irs[2] = 32'h0000007F;
    ir = 32'h123450B7; pc1 = 32'h200; valid_in = 1'b1;
    tick();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ir = stall_irs[i]; pc1 = 32'h204 + 32'(4 * i);
      #1;
      n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL stall_out_%0d got %0b want 1", i, stall_out); end
      tick();
      n_tests++; if ({valid_out, pc_out, imm, is_lui, rd, reg_we, illegal} !== {1'b1, 32'h200, 32'h1234_5000, 1'b1, 5'd1, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold_%0d v=%0b pc=%h imm=%h lui=%0b rd=%0d", i, valid_out, pc_out, imm, is_lui, rd);
      end
    end
    stall_in = 1'b0;
  endtask

  task automatic test_illegal();
    ir = 32'h022081B3; pc1 = 32'h300;  // mul x3,x1,x2
    tick();
`ifdef DECODE_RV32M_EN
    n_tests++; if ({alu_op, illegal, reg_we} !== {4'hA, 1'b0, 1'b1}) begin n_fail++; $display("FAIL mul_m alu=%h ill=%0b we=%0b want a/0/1", alu_op, illegal, reg_we); end
`else
    n_tests++; if ({illegal, reg_we} !== {1'b1, 1'b0}) begin n_fail++; $display("FAIL mul_base ill=%0b we=%0b want 1/0", illegal, reg_we); end
`endif
    ir = 32'h402081B3;  // sub x3,x1,x2
    tick();
    n_tests++; if ({alu_op, illegal, reg_we} !== {4'h1, 1'b0, 1'b1}) begin n_fail++; $display("FAIL sub alu=%h ill=%0b we=%0b", alu_op, illegal, reg_we); end
    ir = 32'h402091B3;  // sll with funct7=0100000
    tick();
    n_tests++; if ({illegal, reg_we} !== {1'b1, 1'b0}) begin n_fail++; $display("FAIL sll_alt ill=%0b we=%0b want 1/0", illegal, reg_we); end
    ir = 32'h0000007F;
    tick();
    n_tests++; if ({illegal, reg_we, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, valid_out} !== 10'b10_0000000_1) begin
      n_fail++; $display("FAIL opc_7f ill=%0b we=%0b flags=%b v=%0b", illegal, reg_we, {is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc}, valid_out);
    end
    ir = 32'h00500090;  // addi with ir[1:0]=00
    tick();
    n_tests++; if ({illegal, reg_we} !== {1'b1, 1'b0}) begin n_fail++; $display("FAIL low_bits ill=%0b we=%0b want 1/0", illegal, reg_we); end
  endtask

  task automatic test_saturate();
    ir = 32'h002081B3; valid_in = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_tests++; if (bubble_cnt !== ((3 + i > 7) ? 3'd7 : 3'(3 + i))) begin n_fail++; $display("FAIL sat_%0d cnt=%0d", i, bubble_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    stall_in = 1'b1; flush = 1'b1; reset = 1'b0;
    tick();
    n_tests++; if ({valid_out, pc_out, bubble_cnt, rd, imm} !== {1'b0, 32'h8000, 3'd0, 5'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_mid v=%0b pc=%h cnt=%0d rd=%0d imm=%h", valid_out, pc_out, bubble_cnt, rd, imm);
    end
    reset = 1'b1; stall_in = 1'b0; flush = 1'b0; ex_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ir = '0; pc1 = '0; valid_in = 1'b0; stall_in = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    tick();
    test_reset();
    test_decode();
    test_hazard();
    test_flush();
    test_stall();
    test_illegal();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
